// File: rtl/mem_stream_loader.sv
// mem_stream_loader: turns a valid/ready byte stream into aligned 32-bit
// strobed write requests on the PicoRV32 native memory bus, starting at
// BASE_ADDR and covering LENGTH bytes per load.
module mem_stream_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] LENGTH    = 32'd512
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        done,
  output logic [31:0] byte_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] ptr_reg;
  logic [31:0] count_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;

  logic        start_ok;
  logic        accept;
  logic        complete;
  logic [31:0] count_inc;
  logic        last_byte;
  logic [1:0]  lane;

  // A start only counts while no load is in progress.
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign accept    = (state_reg == FILL) && in_valid;
  assign complete  = (state_reg == WRITE) && mem_ready;
  assign count_inc = count_reg + 32'd1;
  assign last_byte = (count_inc == LENGTH);
  assign lane      = ptr_reg[1:0];

  assign mem_instr  = 1'b0;
  assign mem_addr   = addr_reg;
  assign mem_wdata  = wdata_reg;
  assign mem_wstrb  = wstrb_reg;
  assign byte_count = count_reg;

  // State register; reset drops any pending request immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mem_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (LENGTH == 32'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // Flush the word once lane 3 is written or the stream is exhausted.
        if (in_valid && ((lane == 2'd3) || last_byte)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_valid = 1'b1;
        busy      = 1'b1;
        if (mem_ready) begin
          state_next = (count_reg == LENGTH) ? DONE : FILL;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_next = (LENGTH == 32'd0) ? DONE : FILL;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pointer, byte counter and the word being assembled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_reg   <= 32'd0;
      count_reg <= 32'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      wstrb_reg <= 4'd0;
    end else begin
      if (start_ok) begin
        ptr_reg   <= BASE_ADDR;
        count_reg <= 32'd0;
        wdata_reg <= 32'd0;
        wstrb_reg <= 4'd0;
      end
      if (accept) begin
        wdata_reg[{lane, 3'b000} +: 8] <= in_data;
        wstrb_reg[lane]                <= 1'b1;
        addr_reg  <= {ptr_reg[31:2], 2'b00};
        ptr_reg   <= ptr_reg + 32'd1;
        count_reg <= count_inc;
      end
      // Lanes are cleared after each write so unstrobed lanes read as zero.
      if (complete) begin
        wdata_reg <= 32'd0;
        wstrb_reg <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Testbench for mem_stream_loader: several instances with different
// BASE_ADDR/LENGTH share the stream and memory inputs; each scenario starts
// only its own instance and compares the bus against a word-grouping model.
`timescale 1ns/1ps
module tb_mem_stream_loader;

  localparam int NI = 5;

  function automatic logic [31:0] base_of(input int i);
    case (i)
      1:       return 32'h0000_0102;
      2:       return 32'h0000_1000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] len_of(input int i);
    case (i)
      0:       return 32'd8;
      1:       return 32'd5;
      2:       return 32'd512;
      3:       return 32'd6;
      default: return 32'd0;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          resetn;
  logic [NI-1:0] start_v;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          mem_ready;

  logic        in_ready_a   [NI];
  logic        mem_valid_a  [NI];
  logic        mem_instr_a  [NI];
  logic        busy_a       [NI];
  logic        done_a       [NI];
  logic [31:0] mem_addr_a   [NI];
  logic [31:0] mem_wdata_a  [NI];
  logic [31:0] byte_count_a [NI];
  logic [3:0]  mem_wstrb_a  [NI];

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  stim_q[$];
  logic [31:0] xs;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    mem_stream_loader #(
      .BASE_ADDR(base_of(gi)),
      .LENGTH   (len_of(gi))
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start_v[gi]),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready_a[gi]),
      .mem_valid (mem_valid_a[gi]),
      .mem_instr (mem_instr_a[gi]),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr_a[gi]),
      .mem_wdata (mem_wdata_a[gi]),
      .mem_wstrb (mem_wstrb_a[gi]),
      .busy      (busy_a[gi]),
      .done      (done_a[gi]),
      .byte_count(byte_count_a[gi])
    );
  end

  always #5 clk = ~clk;

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Drive one full load on instance sel with the bytes in stim_q and check
  // every write against words grouped from byte addresses base+i.
  task automatic run_load(input int sel, input int gap, input bit wait_mode, input string tag);
    logic [31:0] base;
    logic [31:0] n;
    logic [31:0] e_addr[$];
    logic [31:0] e_data[$];
    logic [3:0]  e_strb[$];
    int          e_end[$];
    logic [31:0] cw;
    logic [31:0] cd;
    logic [3:0]  cs;
    logic [31:0] a;
    logic [7:0]  mem_model [logic [31:0]];
    int          acc;
    int          txn;
    int          gapc;
    int          cyc;
    bit          final_seen;
    bit          waiting;
    bit          post_cmp;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_strb;
    base = base_of(sel);
    n    = len_of(sel);
    cw = '0; cd = '0; cs = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = base + 32'(i);
      if (i == 0 || {a[31:2], 2'b00} != cw) begin
        if (i != 0) begin
          e_addr.push_back(cw); e_data.push_back(cd); e_strb.push_back(cs); e_end.push_back(i);
        end
        cw = {a[31:2], 2'b00}; cd = '0; cs = '0;
      end
      cd[{a[1:0], 3'b000} +: 8] = stim_q[i];
      cs[a[1:0]] = 1'b1;
    end
    e_addr.push_back(cw); e_data.push_back(cd); e_strb.push_back(cs); e_end.push_back(int'(n));

    @(negedge clk);
    in_valid = 1'b0;
    start_v[sel] = 1'b1;
    @(negedge clk);
    start_v[sel] = 1'b0;
    n_checks++;
    if (in_ready_a[sel] !== 1'b1) begin
      n_fail++; $display("FAIL %s start_to_ready: got %b expected 1", tag, in_ready_a[sel]);
    end

    acc = 0; txn = 0; gapc = 0; cyc = 0;
    final_seen = 0; waiting = 0; post_cmp = 0;
    h_addr = '0; h_data = '0; h_strb = '0;
    forever begin
      if (final_seen) begin
        n_checks++;
        if (done_a[sel] !== 1'b1 || busy_a[sel] !== 1'b0 || mem_valid_a[sel] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s done_after_last: got done=%b busy=%b mem_valid=%b expected 1 0 0",
                   tag, done_a[sel], busy_a[sel], mem_valid_a[sel]);
        end
        n_checks++;
        if (byte_count_a[sel] !== n) begin
          n_fail++; $display("FAIL %s byte_count: got %0d expected %0d", tag, byte_count_a[sel], n);
        end
        break;
      end
      if (cyc > 20000) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: got %0d writes expected %0d", tag, txn, e_addr.size());
        break;
      end
      if (acc < int'(n) && gapc == 0) begin
        in_valid = 1'b1; in_data = stim_q[acc];
      end else begin
        in_valid = 1'b0;
      end
      if (wait_mode) begin
        xs = xs ^ (xs << 13); xs = xs ^ (xs >> 17); xs = xs ^ (xs << 5);
        mem_ready = xs[0];
      end else begin
        mem_ready = 1'b1;
      end
      n_checks++;
      if (mem_instr_a[sel] !== 1'b0 || (in_ready_a[sel] & mem_valid_a[sel]) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s bus_sanity: got instr=%b ready&valid=%b expected 0 0",
                 tag, mem_instr_a[sel], in_ready_a[sel] & mem_valid_a[sel]);
      end
      if (post_cmp) begin
        n_checks++;
        if (mem_valid_a[sel] !== 1'b0) begin
          n_fail++; $display("FAIL %s idle_after_write: got mem_valid=%b expected 0", tag, mem_valid_a[sel]);
        end
        post_cmp = 0;
      end
      if (mem_valid_a[sel] === 1'b1) begin
        if (waiting) begin
          n_checks++;
          if (mem_addr_a[sel] !== h_addr || mem_wdata_a[sel] !== h_data || mem_wstrb_a[sel] !== h_strb) begin
            n_fail++;
            $display("FAIL %s hold_stable: got %h/%h/%h expected %h/%h/%h", tag,
                     mem_addr_a[sel], mem_wdata_a[sel], mem_wstrb_a[sel], h_addr, h_data, h_strb);
          end
        end else if (txn >= e_addr.size()) begin
          n_checks++; n_fail++;
          $display("FAIL %s extra_write: got write %0d expected %0d writes", tag, txn + 1, e_addr.size());
        end else begin
          n_checks++;
          if (mem_addr_a[sel] !== e_addr[txn] || mem_wdata_a[sel] !== e_data[txn] ||
              mem_wstrb_a[sel] !== e_strb[txn]) begin
            n_fail++;
            $display("FAIL %s write%0d: got %h/%h/%h expected %h/%h/%h", tag, txn,
                     mem_addr_a[sel], mem_wdata_a[sel], mem_wstrb_a[sel],
                     e_addr[txn], e_data[txn], e_strb[txn]);
          end
          n_checks++;
          if (acc != e_end[txn]) begin
            n_fail++; $display("FAIL %s write%0d_timing: got %0d bytes expected %0d", tag, txn, acc, e_end[txn]);
          end
        end
        if (mem_ready) begin
          for (int l = 0; l < 4; l++) begin
            if (mem_wstrb_a[sel][l]) mem_model[mem_addr_a[sel] + 32'(l)] = mem_wdata_a[sel][l*8 +: 8];
          end
          txn++;
          waiting = 0;
          if (txn == e_addr.size()) final_seen = 1; else post_cmp = 1;
        end else begin
          waiting = 1;
          h_addr = mem_addr_a[sel]; h_data = mem_wdata_a[sel]; h_strb = mem_wstrb_a[sel];
        end
      end
      if (in_ready_a[sel] === 1'b1 && in_valid) begin
        acc++; gapc = gap;
      end else if (!in_valid && gapc > 0) begin
        gapc--;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      a = base + 32'(i);
      n_checks++;
      if (!mem_model.exists(a)) begin
        n_fail++; $display("FAIL %s mem[%h]: got unwritten expected %h", tag, a, stim_q[i]);
      end else if (mem_model[a] !== stim_q[i]) begin
        n_fail++; $display("FAIL %s mem[%h]: got %h expected %h", tag, a, mem_model[a], stim_q[i]);
      end
    end
    $display("run %s: %0d bytes, %0d writes, %0d cycles", tag, acc, txn, cyc);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < NI; i++) begin
      n_checks++;
      if (in_ready_a[i] !== 1'b0 || mem_valid_a[i] !== 1'b0 || mem_instr_a[i] !== 1'b0 ||
          busy_a[i] !== 1'b0 || done_a[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: got rdy=%b val=%b ins=%b busy=%b done=%b expected all 0", i,
                 in_ready_a[i], mem_valid_a[i], mem_instr_a[i], busy_a[i], done_a[i]);
      end
      n_checks++;
      if (mem_addr_a[i] !== 32'd0 || mem_wdata_a[i] !== 32'd0 || mem_wstrb_a[i] !== 4'd0 ||
          byte_count_a[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_values[%0d]: got %h/%h/%h/%h expected zeros", i,
                 mem_addr_a[i], mem_wdata_a[i], mem_wstrb_a[i], byte_count_a[i]);
      end
    end
    $display("reset: %0d instances checked", NI);
  endtask

  task automatic test_aligned();
    stim_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(0, 0, 1'b0, "aligned");
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    run_load(0, 0, 1'b0, "restart_from_done");
  endtask

  task automatic test_unaligned();
    stim_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(1, 0, 1'b0, "unaligned");
  endtask

  task automatic test_stream_gaps();
    stim_q.delete();
    for (int i = 0; i < 6; i++) stim_q.push_back(8'($urandom));
    run_load(3, 3, 1'b0, "stream_gaps");
  endtask

  task automatic test_wait_states();
    xs = 32'd314159265;
    stim_q.delete();
    for (int i = 0; i < 512; i++) stim_q.push_back(8'($urandom));
    run_load(2, 0, 1'b1, "wait_states");
  endtask

  task automatic test_start_in_fill();
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    do_reset();
    mem_ready = 1'b0;
    in_valid  = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = b[k];
      @(negedge clk);
    end
    in_valid   = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n_checks++;
    if (byte_count_a[0] !== 32'd3 || busy_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL start_in_fill: got count=%0d busy=%b expected 3 1", byte_count_a[0], busy_a[0]);
    end
    in_valid = 1'b1; in_data = b[3];
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (mem_valid_a[0] !== 1'b1 || mem_addr_a[0] !== 32'd0 ||
        mem_wdata_a[0] !== {b[3], b[2], b[1], b[0]} || mem_wstrb_a[0] !== 4'hF) begin
      n_fail++;
      $display("FAIL start_in_fill_word: got %b %h/%h/%h expected 1 00000000/%h/f", mem_valid_a[0],
               mem_addr_a[0], mem_wdata_a[0], mem_wstrb_a[0], {b[3], b[2], b[1], b[0]});
    end
    $display("start_in_fill: count=%0d word=%h", byte_count_a[0], mem_wdata_a[0]);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    mem_ready = 1'b0;
    in_valid  = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_valid_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_write_setup: got mem_valid=%b expected 1", mem_valid_a[0]);
    end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (mem_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || done_a[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_write: got val=%b busy=%b done=%b expected 0 0 0",
               mem_valid_a[0], busy_a[0], done_a[0]);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    stim_q.delete();
    for (int i = 0; i < 8; i++) stim_q.push_back(8'($urandom));
    run_load(0, 0, 1'b0, "reload_after_reset");
  endtask

  task automatic test_zero_length();
    @(negedge clk);
    start_v[4] = 1'b1;
    @(negedge clk);
    start_v[4] = 1'b0;
    n_checks++;
    if (done_a[4] !== 1'b1 || busy_a[4] !== 1'b0 || mem_valid_a[4] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_length: got done=%b busy=%b val=%b expected 1 0 0", done_a[4], busy_a[4], mem_valid_a[4]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (mem_valid_a[4] !== 1'b0 || done_a[4] !== 1'b1) begin
        n_fail++; $display("FAIL zero_length_hold: got val=%b done=%b expected 0 1", mem_valid_a[4], done_a[4]);
      end
    end
    $display("zero_length: done=%b", done_a[4]);
  endtask

  initial begin
    resetn    = 1'b0;
    start_v   = '0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    mem_ready = 1'b0;
    xs        = 32'd314159265;
    test_reset();
    test_aligned();
    test_unaligned();
    test_stream_gaps();
    test_wait_states();
    test_start_in_fill();
    test_reset_mid_write();
    test_zero_length();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
